w_control: RTL and testbench
============================

Name: w_control

Overview:
- Write-side control for the dual-clock asynchronous FIFO; mirror of the existing read-side controller.
- Owns the binary write counter, the RAM write address/enable and the Gray-coded write pointer sent to the read domain.
- Synchronizes the read pointer in from the read domain and produces full, almost-full and a conservative fill level.
- Sits in the write-clock domain between the producer and the FIFO dual-port RAM.

Parameters:
ADDSIZE, 8, address width; DEPTH = 1<<ADDSIZE entries; legal range 2..16
AFULL_MARGIN, 2, walmost_full asserts when free entries <= AFULL_MARGIN; legal range 1..DEPTH-1

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  reset; one clock; reset is synchronous and active-low
winc  input  1  producer write request
rptr  input  ADDSIZE+1  Gray read pointer from read domain (asynchronous to wclk)
wen  output  1  RAM write strobe = winc & ~wfull (combinational)
waddr  output  ADDSIZE  RAM write address = wbin[ADDSIZE-1:0]
wptr  output  ADDSIZE+1  registered Gray write pointer to read domain
wfull  output  1  FIFO full, registered
walmost_full  output  1  level >= DEPTH-AFULL_MARGIN, registered
wlevel  output  ADDSIZE+1  conservative occupancy 0..DEPTH, registered

Behaviour:
- Reset (wrst_n low at a wclk edge): wbin, wptr, both rptr sync stages, wfull, walmost_full and wlevel all become 0. waddr=0. wen=0 while wfull=0 only if winc=0.
- Reset outranks every other event, including mid-burst and while full.
- Read-pointer sync: two-flop chain rq1 <= rptr, rq2 <= rq1. Only rq2 is used.
- Write accept:
  - A write is accepted when winc=1 and the registered wfull=0 in that cycle.
  - wbin_next = wbin + accept, modulo 2^(ADDSIZE+1).
  - wgray_next = (wbin_next>>1) ^ wbin_next.
  - At every edge: wbin <= wbin_next, wptr <= wgray_next.
- Full:
  - wfull <= (wgray_next == {~rq2[ADDSIZE:ADDSIZE-1], rq2[ADDSIZE-2:0]}).
  - The write that fills the last slot is accepted; wfull is 1 from the next cycle.
- Write while full: dropped. wen=0; waddr and wptr hold.
- Level:
  - rbin = Gray-to-binary of rq2.
  - level_next = wbin_next - rbin, modulo 2^(ADDSIZE+1).
  - wlevel <= level_next.
  - walmost_full <= (level_next >= DEPTH-AFULL_MARGIN).
- Latency:
  - A write is visible in wptr, wlevel and wfull one edge after acceptance.
  - A change on rptr affects wfull, wlevel and walmost_full at the 3rd wclk edge (2 sync + 1 register).
  - Flags are pessimistic: they may report full or late release, never falsely not-full.
- Wrap-around: counter and pointer wrap silently at 2^(ADDSIZE+1). The MSB lap bit distinguishes full from empty.
- Single Gray bit change per cycle on wptr is mandatory; no glitching logic on wptr.

Optional Feature:
Macro W_CTRL_OVF_EN.
- Defined:
  - Adds output wovf (1 bit): sticky flag, set at the edge after any winc & wfull, cleared only by reset.
  - Adds output wovf_cnt (8 bits): counts dropped writes, saturates at 255, reset 0.
- Undefined: both ports and their logic are absent. Core behaviour is identical in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - functions bin2gray and gray2bin, width-generic on ADDSIZE+1;
  - default ADDSIZE constant;
  - DEPTH derivation.
- The read-side controller imports the same package.
- One sub-module: sync_2ff, a parameterized-width two-flop synchronizer with synchronous active-low reset. It is instantiated here for rptr and is reusable on the read side for wptr.

Test Plan (ADDSIZE=4, DEPTH=16, AFULL_MARGIN=2):
- Reset: wrst_n=0 for 2 edges with winc=1 and rptr=5'b10101 -> waddr=0, wptr=0, wfull=0, wlevel=0, walmost_full=0. The first accepted write occurs after wrst_n rises.
- Fill: rptr held 0, winc=1 for 16 cycles.
  - wptr steps 00001, 00011, 00010, 00110, ...
  - walmost_full=1 after the 14th write (wlevel=14).
  - After the 16th write: wptr=11000, wlevel=16, wfull=1, wen=0.
- Write while full: winc=1 for 3 more cycles -> waddr=0 and wptr=11000 unchanged. With W_CTRL_OVF_EN: wovf=1, wovf_cnt=3.
- Release: from full, drive rptr=00001 -> wfull=0, wlevel=15 and walmost_full=1 at the 3rd edge. The next write lands at waddr=0 and wptr becomes 11001.
- Wrap: stream 40 writes with rptr trailing by 4 entries (gray of wbin-4) -> wfull never asserts, waddr wraps 15->0 and wptr MSB toggles at write 16 and 32, wlevel settles at 6 or less after sync.
- Mid-op reset: assert wrst_n=0 while full with wovf set -> all outputs 0 at the next edge, and wovf=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray conversion and depth derivation.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  localparam int ADDSIZE_DEF = 8;
  localparam int PW_MAX      = 17;

  typedef logic [PW_MAX-1:0] ptr_t;

  function automatic int depth_of(input int addsize);
    return 1 << addsize;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW_MAX-1] = g[PW_MAX-1];
    for (int i = PW_MAX-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for Gray pointers crossing clock domains.
// Synchronous active-low reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1_q;
  logic [WIDTH-1:0] q2_q;

  // two-stage capture of the foreign-domain value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d;
      q2_q <= q1_q;
    end
  end

  assign q = q2_q;

endmodule

// File: rtl/w_control.sv
// Write-domain controller for the dual-clock FIFO.
// Define W_CTRL_OVF_EN to add the dropped-write flag and counter.
module w_control
  import fifo_pkg::*;
#(
  parameter int ADDSIZE      = ADDSIZE_DEF,
  parameter int AFULL_MARGIN = 2
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               winc,
  input  logic [ADDSIZE:0]   rptr,
  output logic               wen,
  output logic [ADDSIZE-1:0] waddr,
  output logic [ADDSIZE:0]   wptr,
  output logic               wfull,
`ifdef W_CTRL_OVF_EN
  output logic               wovf,
  output logic [7:0]         wovf_cnt,
`endif
  output logic               walmost_full,
  output logic [ADDSIZE:0]   wlevel
);

  localparam int DEPTH = depth_of(ADDSIZE);
  localparam logic [ADDSIZE:0] AF_TH =
    (ADDSIZE+1)'(DEPTH - AFULL_MARGIN);

  logic [ADDSIZE:0] rq2;

  logic [ADDSIZE:0] wbin_q, wbin_d;
  logic [ADDSIZE:0] wptr_q, wptr_d;
  logic [ADDSIZE:0] wlevel_q, wlevel_d;
  logic             wfull_q, wfull_d;
  logic             walmost_full_q, walmost_full_d;

  logic             accept;
  logic [ADDSIZE:0] full_cmp;
  ptr_t             wbin_x, wgray_x, rq2_x, rbin_x;
  logic             unused_hi;

  sync_2ff #(.WIDTH(ADDSIZE+1)) u_rsync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr),
    .q     (rq2)
  );

  // next counter, Gray pointer, full and level from synced rptr
  always_comb begin
    accept  = winc & ~wfull_q;
    wbin_d  = wbin_q + {{ADDSIZE{1'b0}}, accept};
    wbin_x  = '0;
    wbin_x[ADDSIZE:0] = wbin_d;
    wgray_x = bin2gray(wbin_x);
    wptr_d  = wgray_x[ADDSIZE:0];
    rq2_x   = '0;
    rq2_x[ADDSIZE:0] = rq2;
    rbin_x  = gray2bin(rq2_x);
    full_cmp = {~rq2[ADDSIZE:ADDSIZE-1], rq2[ADDSIZE-2:0]};
    wfull_d  = (wptr_d == full_cmp);
    wlevel_d = wbin_d - rbin_x[ADDSIZE:0];
    walmost_full_d = (wlevel_d >= AF_TH);
  end

  // upper bits of the wide helper results are always zero
  assign unused_hi = ^{wgray_x, rbin_x};

  // write-side state registers
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
    end
  end

  assign wen          = winc & ~wfull_q;
  assign waddr        = wbin_q[ADDSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;

`ifdef W_CTRL_OVF_EN
  logic       wovf_q, wovf_d;
  logic [7:0] wovf_cnt_q, wovf_cnt_d;
  logic       drop;

  // sticky overflow flag and saturating drop counter
  always_comb begin
    drop       = winc & wfull_q;
    wovf_d     = wovf_q | drop;
    wovf_cnt_d = wovf_cnt_q;
    if (drop && wovf_cnt_q != 8'hff)
      wovf_cnt_d = wovf_cnt_q + 8'd1;
  end

  // overflow state registers
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wovf_q     <= 1'b0;
      wovf_cnt_q <= '0;
    end else begin
      wovf_q     <= wovf_d;
      wovf_cnt_q <= wovf_cnt_d;
    end
  end

  assign wovf     = wovf_q;
  assign wovf_cnt = wovf_cnt_q;
`endif

endmodule

// File: tb/tb_w_control.sv
// Directed bench for w_control at ADDSIZE=4, AFULL_MARGIN=2.
// Build with W_CTRL_OVF_EN to also check the overflow outputs.
module tb_w_control;

  logic       clk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic [4:0] rptr = '0;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
`ifdef W_CTRL_OVF_EN
  logic       wovf;
  logic [7:0] wovf_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  w_control #(.ADDSIZE(4), .AFULL_MARGIN(2)) dut (
    .wclk         (clk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr         (rptr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
`ifdef W_CTRL_OVF_EN
    .wovf         (wovf),
    .wovf_cnt     (wovf_cnt),
`endif
    .walmost_full (walmost_full),
    .wlevel       (wlevel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with write request and junk rptr
    wrst_n = 1'b0; winc = 1'b1; rptr = 5'b10101;
    tick; tick;
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wptr", 32'(wptr), 32'd0);
    chk("rst_wfull", 32'(wfull), 32'd0);
    chk("rst_wlevel", 32'(wlevel), 32'd0);
    chk("rst_afull", 32'(walmost_full), 32'd0);
`ifdef W_CTRL_OVF_EN
    chk("rst_wovf", 32'(wovf), 32'd0);
    chk("rst_ovfcnt", 32'(wovf_cnt), 32'd0);
`endif

    // fill 16 entries
    wrst_n = 1'b1; rptr = '0; winc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("fill_wen", 32'(wen), 32'd1);
      chk("fill_waddr", 32'(waddr), 32'(k-1));
      tick;
      chk("fill_wptr", 32'(wptr), 32'(g(5'(k))));
      chk("fill_level", 32'(wlevel), 32'(k));
      chk("fill_afull", 32'(walmost_full), 32'(k >= 14));
      chk("fill_full", 32'(wfull), 32'(k == 16));
    end
    chk("full_wptr", 32'(wptr), 32'b11000);
    #1;
    chk("full_wen", 32'(wen), 32'd0);

    // writes while full are dropped
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("drop_waddr", 32'(waddr), 32'd0);
      chk("drop_wptr", 32'(wptr), 32'b11000);
      chk("drop_full", 32'(wfull), 32'd1);
    end
`ifdef W_CTRL_OVF_EN
    chk("drop_wovf", 32'(wovf), 32'd1);
    chk("drop_ovfcnt", 32'(wovf_cnt), 32'd3);
`endif

    // release: reader advances by one
    winc = 1'b0; rptr = 5'b00001;
    tick; tick;
    chk("rel_full_e2", 32'(wfull), 32'd1);
    tick;
    chk("rel_full_e3", 32'(wfull), 32'd0);
    chk("rel_level", 32'(wlevel), 32'd15);
    chk("rel_afull", 32'(walmost_full), 32'd1);
    winc = 1'b1;
    #1;
    chk("rel_wen", 32'(wen), 32'd1);
    chk("rel_waddr", 32'(waddr), 32'd0);
    tick;
    chk("rel_wptr", 32'(wptr), 32'b11001);
    chk("rel_level2", 32'(wlevel), 32'd16);
    chk("rel_full2", 32'(wfull), 32'd1);
`ifdef W_CTRL_OVF_EN
    chk("rel_ovfcnt", 32'(wovf_cnt), 32'd3);
`endif

    // reset while full and overflowed
    wrst_n = 1'b0; winc = 1'b1;
    tick;
    chk("mrst_waddr", 32'(waddr), 32'd0);
    chk("mrst_wptr", 32'(wptr), 32'd0);
    chk("mrst_wfull", 32'(wfull), 32'd0);
    chk("mrst_wlevel", 32'(wlevel), 32'd0);
    chk("mrst_afull", 32'(walmost_full), 32'd0);
`ifdef W_CTRL_OVF_EN
    chk("mrst_wovf", 32'(wovf), 32'd0);
    chk("mrst_ovfcnt", 32'(wovf_cnt), 32'd0);
`endif
    wrst_n = 1'b1; winc = 1'b0; rptr = '0;
    tick;

    // stream 40 writes with reader trailing by 4
    for (int i = 0; i < 40; i++) begin
      rptr = g(5'((i >= 4) ? i - 4 : 0));
      winc = 1'b1;
      #1;
      chk("wrap_nfull", 32'(wfull), 32'd0);
      chk("wrap_waddr", 32'(waddr), 32'(i % 16));
      tick;
      chk("wrap_wptr", 32'(wptr), 32'(g(5'(i+1))));
      if (i + 1 == 16)
        chk("wrap_msb16", 32'(wptr[4]), 32'd1);
      if (i + 1 == 32)
        chk("wrap_msb32", 32'(wptr[4]), 32'd0);
    end
    winc = 1'b0; rptr = 5'b00110;
    tick; tick; tick;
    chk("wrap_level", 32'(wlevel), 32'd4);
    chk("wrap_afull", 32'(walmost_full), 32'd0);
    chk("wrap_full", 32'(wfull), 32'd0);
    chk("wrap_wptr_end", 32'(wptr), 32'b01100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
